// File: rtl/kamikaze_defs.sv
// Shared decode definitions for the Kamikaze-uRV pipeline: major opcodes (ir[6:2])
// and immediate formats.
package kamikaze_defs;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/kamikaze_imm_gen.sv
// Immediate generator: builds the sign-extended 32-bit immediate of an RV32I
// instruction from its encoding and the immediate format selected by decode.
module kamikaze_imm_gen
    import kamikaze_defs::*;
(
    input  logic [31:7] ir,
    input  logic [2:0]  fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'h0;
        case (fmt)
            FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
            FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_U:   imm = {ir[31:12], 12'h000};
            FMT_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/kamikaze_decode.sv
// Kamikaze-uRV decode stage: registers the fetched instruction, decodes control fields
// and immediate, drives regfile read addresses and bubbles on load-use hazards.
module kamikaze_decode
    import kamikaze_defs::*;
#(
    parameter bit WITH_MULDIV = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        d_stall_i,
    input  logic        d_kill_i,
    input  logic        f_valid_i,
    input  logic [31:0] f_ir_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_is_compressed_i,
    output logic        d_stall_o,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic        d_valid_o,
    output logic [31:0] d_pc_o,
    output logic [31:0] d_pc_next_o,
    output logic [4:0]  d_opcode_o,
    output logic [2:0]  d_fun3_o,
    output logic [6:0]  d_fun7_o,
    output logic [4:0]  d_rs1_o,
    output logic [4:0]  d_rs2_o,
    output logic [4:0]  d_rd_o,
    output logic        d_rd_write_o,
    output logic [31:0] d_imm_o,
    output logic        d_is_load_o,
    output logic        d_is_store_o,
    output logic        d_is_branch_o,
    output logic        d_is_jal_o,
    output logic        d_is_jalr_o,
    output logic        d_is_system_o,
    output logic        d_illegal_o
);

    logic [4:0]  opc;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [4:0]  f_rd;
    logic        legal_opc;
    logic        has_rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_system;
    logic        muldiv_bad;
    logic        illegal;
    imm_fmt_e    fmt;
    logic [31:0] imm;
    logic [31:0] pc_next;
    logic        load_hazard;

    assign opc   = f_ir_i[6:2];
    assign f_rs1 = f_ir_i[19:15];
    assign f_rs2 = f_ir_i[24:20];
    assign f_rd  = f_ir_i[11:7];

    // Class flags stay clear for non-32-bit encodings so they never look like a load.
    always_comb begin
        legal_opc = 1'b0;
        has_rd    = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_system = 1'b0;
        fmt       = FMT_R;
        case (opc)
            OPC_LOAD:     begin legal_opc = 1'b1; has_rd = 1'b1; is_load = 1'b1; fmt = FMT_I; end
            OPC_MISC_MEM: begin legal_opc = 1'b1; fmt = FMT_I; end
            OPC_OP_IMM:   begin legal_opc = 1'b1; has_rd = 1'b1; fmt = FMT_I; end
            OPC_AUIPC:    begin legal_opc = 1'b1; has_rd = 1'b1; uses_rs1 = 1'b0; fmt = FMT_U; end
            OPC_STORE:    begin legal_opc = 1'b1; uses_rs2 = 1'b1; is_store = 1'b1; fmt = FMT_S; end
            OPC_OP:       begin legal_opc = 1'b1; has_rd = 1'b1; uses_rs2 = 1'b1; end
            OPC_LUI:      begin legal_opc = 1'b1; has_rd = 1'b1; uses_rs1 = 1'b0; fmt = FMT_U; end
            OPC_BRANCH:   begin legal_opc = 1'b1; uses_rs2 = 1'b1; is_branch = 1'b1; fmt = FMT_B; end
            OPC_JALR:     begin legal_opc = 1'b1; has_rd = 1'b1; is_jalr = 1'b1; fmt = FMT_I; end
            OPC_JAL:      begin
                legal_opc = 1'b1; has_rd = 1'b1; uses_rs1 = 1'b0; is_jal = 1'b1; fmt = FMT_J;
            end
            OPC_SYSTEM:   begin legal_opc = 1'b1; has_rd = 1'b1; is_system = 1'b1; fmt = FMT_I; end
            default:      ;
        endcase

        muldiv_bad = (opc == OPC_OP) && (f_ir_i[31:25] == FUNCT7_MULDIV) && !WITH_MULDIV;
        illegal    = !legal_opc || (f_ir_i[1:0] != 2'b11) || muldiv_bad;

        if (illegal) begin
            has_rd    = 1'b0;
            is_load   = 1'b0;
            is_store  = 1'b0;
            is_branch = 1'b0;
            is_jal    = 1'b0;
            is_jalr   = 1'b0;
            is_system = 1'b0;
            fmt       = FMT_R;
        end
    end

    kamikaze_imm_gen u_imm_gen (
        .ir  (f_ir_i[31:7]),
        .fmt (fmt),
        .imm (imm)
    );

    assign pc_next = f_pc_i + (f_is_compressed_i ? 32'd2 : 32'd4);

    assign load_hazard = d_valid_o & d_is_load_o & (d_rd_o != 5'd0) & f_valid_i &
                         ((uses_rs1 & (f_rs1 == d_rd_o)) | (uses_rs2 & (f_rs2 == d_rd_o)));

    assign d_stall_o = d_stall_i | load_hazard;

    // While execute is busy, keep presenting the held operands so regfile data stays aligned.
    assign rf_rs1_o = d_stall_i ? d_rs1_o : f_rs1;
    assign rf_rs2_o = d_stall_i ? d_rs2_o : f_rs2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_valid_o     <= 1'b0;
            d_pc_o        <= 32'h0;
            d_pc_next_o   <= 32'h0;
            d_opcode_o    <= 5'h0;
            d_fun3_o      <= 3'h0;
            d_fun7_o      <= 7'h0;
            d_rs1_o       <= 5'h0;
            d_rs2_o       <= 5'h0;
            d_rd_o        <= 5'h0;
            d_rd_write_o  <= 1'b0;
            d_imm_o       <= 32'h0;
            d_is_load_o   <= 1'b0;
            d_is_store_o  <= 1'b0;
            d_is_branch_o <= 1'b0;
            d_is_jal_o    <= 1'b0;
            d_is_jalr_o   <= 1'b0;
            d_is_system_o <= 1'b0;
            d_illegal_o   <= 1'b0;
        end else begin
            if (d_kill_i) begin
                d_valid_o <= 1'b0;
            end else if (!d_stall_i) begin
                d_valid_o <= f_valid_i & ~load_hazard;
            end

            if (!d_stall_i) begin
                d_pc_o        <= f_pc_i;
                d_pc_next_o   <= pc_next;
                d_opcode_o    <= opc;
                d_fun3_o      <= f_ir_i[14:12];
                d_fun7_o      <= f_ir_i[31:25];
                d_rs1_o       <= f_rs1;
                d_rs2_o       <= f_rs2;
                d_rd_o        <= f_rd;
                d_rd_write_o  <= has_rd & (f_rd != 5'd0);
                d_imm_o       <= imm;
                d_is_load_o   <= is_load;
                d_is_store_o  <= is_store;
                d_is_branch_o <= is_branch;
                d_is_jal_o    <= is_jal;
                d_is_jalr_o   <= is_jalr;
                d_is_system_o <= is_system;
                d_illegal_o   <= illegal;
            end
        end
    end

endmodule
